// File: rtl/pc_ras_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_ras_unit
// Brief    : IF-stage program counter with return-address stack. Optional
//            target alignment trap enabled by defining PC_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pc_ras_unit #(
  parameter int unsigned     PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int unsigned     INC       = 4,
  parameter int unsigned     RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'('h100)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            freeze_i,
  input  logic            br_taken_i,
  input  logic [PC_W-1:0] br_target_i,
  input  logic            call_i,
  input  logic            ret_i,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] pc_next_o,
  output logic            ras_empty_o,
  output logic            ras_full_o,
  output logic            ras_ovf_o,
  output logic            ras_unf_o,
  output logic            misalign_o
);

  localparam int unsigned     PTR_W   = $clog2(RAS_DEPTH);
  localparam int unsigned     CNT_W   = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);
  localparam logic [PC_W-1:0] INC_V   = PC_W'(INC);

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  ras_q [RAS_DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wp_q, wp_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  ras_top;
  logic             push, pop;
  logic             tgt_sel;
  logic             mis_d;

  assign pc_inc  = pc_q + INC_V;
  assign ras_top = ras_q[wp_q - PTR_W'(1)];

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'(INC - 1);
`else
  logic unused_trap_vec;
  assign unused_trap_vec = ^TRAP_VEC;
`endif

  always_comb begin
    pc_d    = pc_inc;
    push    = 1'b0;
    pop     = 1'b0;
    tgt_sel = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    mis_d   = 1'b0;
    if (call_i) begin
      pc_d    = br_target_i;
      push    = 1'b1;
      tgt_sel = 1'b1;
      if (cnt_q == CNT_MAX) ovf_d = 1'b1;
    end else if (ret_i) begin
      if (cnt_q != '0) begin
        pc_d = ras_top;
        pop  = 1'b1;
      end else begin
        unf_d = 1'b1;
      end
    end else if (br_taken_i) begin
      pc_d    = br_target_i;
      tgt_sel = 1'b1;
    end
`ifdef PC_ALIGN_CHECK_EN
    // A misaligned call still pushes; only the fetch address is redirected.
    if (tgt_sel && ((br_target_i & ALIGN_MASK) != '0)) begin
      pc_d  = TRAP_VEC;
      mis_d = ~freeze_i;
    end
`endif
  end

  always_comb begin
    cnt_d = cnt_q;
    wp_d  = wp_q;
    if (push) begin
      wp_d = wp_q + 1'b1;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end else if (pop) begin
      wp_d  = wp_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_VEC;
      cnt_q <= '0;
      wp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (!freeze_i) begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      wp_q  <= wp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Entry storage carries no reset; contents are meaningless until pushed.
  always_ff @(posedge clk) begin
    if (!freeze_i && push) ras_q[wp_q] <= pc_inc;
  end

`ifdef PC_ALIGN_CHECK_EN
  logic mis_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= mis_d;
  end
  assign misalign_o = mis_q;
`else
  logic unused_mis;
  assign unused_mis = mis_d;
  assign misalign_o = 1'b0;
`endif

  assign pc_o        = pc_q;
  assign pc_next_o   = pc_d;
  assign ras_empty_o = (cnt_q == '0);
  assign ras_full_o  = (cnt_q == CNT_MAX);
  assign ras_ovf_o   = ovf_q;
  assign ras_unf_o   = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_ras_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_ras_unit
// Brief    : Self-checking bench for pc_ras_unit with a queue-based RAS model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_ras_unit;

  localparam int          DEPTH     = 4;
  localparam int          INC       = 4;
  localparam logic [31:0] RESET_VEC = 32'h0;
  localparam logic [31:0] TRAP_VEC  = 32'h100;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze = 1'b0, br = 1'b0, call = 1'b0, ret = 1'b0;
  logic [31:0] tgt = '0;
  logic [31:0] pc_o, pc_next_o;
  logic        ras_empty_o, ras_full_o, ras_ovf_o, ras_unf_o, misalign_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_ras_unit #(
    .PC_W(32), .RESET_VEC(RESET_VEC), .INC(INC), .RAS_DEPTH(DEPTH), .TRAP_VEC(TRAP_VEC)
  ) dut (
    .clk(clk), .rst(rst), .freeze_i(freeze), .br_taken_i(br), .br_target_i(tgt),
    .call_i(call), .ret_i(ret), .pc_o(pc_o), .pc_next_o(pc_next_o),
    .ras_empty_o(ras_empty_o), .ras_full_o(ras_full_o), .ras_ovf_o(ras_ovf_o),
    .ras_unf_o(ras_unf_o), .misalign_o(misalign_o)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: the stack is a queue, newest at the back, oldest dropped on overflow.
  logic [31:0] m_pc;
  logic [31:0] m_stk[$];
  bit          m_ovf, m_unf, m_mis;

  function automatic bit exp_mis_sel();
`ifdef PC_ALIGN_CHECK_EN
    return (call || (!ret && br)) && ((tgt % INC) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_next();
    if (exp_mis_sel()) return TRAP_VEC;
    if (call) return tgt;
    if (ret) return (m_stk.size() > 0) ? m_stk[$] : m_pc + INC;
    if (br) return tgt;
    return m_pc + INC;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [31:0] nx;
    if (rst) begin
      m_pc = RESET_VEC;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_mis = 1'b0;
    end else if (freeze) begin
      m_mis = 1'b0;
    end else begin
      nx    = exp_next();
      m_mis = exp_mis_sel();
      if (call) begin
        if (m_stk.size() == DEPTH) begin
          m_ovf = 1'b1;
          void'(m_stk.pop_front());
        end
        m_stk.push_back(m_pc + INC);
      end else if (ret) begin
        if (m_stk.size() > 0) void'(m_stk.pop_back());
        else m_unf = 1'b1;
      end
      m_pc = nx;
    end
  end

  always @(posedge clk) begin
    #3;
    check("pc", pc_o, m_pc);
    check("pc_next", pc_next_o, exp_next());
    check("ras_empty", ras_empty_o, m_stk.size() == 0);
    check("ras_full", ras_full_o, m_stk.size() == DEPTH);
    check("ras_ovf", ras_ovf_o, m_ovf);
    check("ras_unf", ras_unf_o, m_unf);
    check("misalign", misalign_o, m_mis);
  end

  task automatic drive(bit f, bit b, bit c, bit r, logic [31:0] t);
    @(negedge clk);
    freeze = f; br = b; call = c; ret = r; tgt = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [31:0] rets [4];
    rets[0] = 32'h4004; rets[1] = 32'h3004; rets[2] = 32'h2004; rets[3] = 32'h1004;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();

    // Asynchronous reset mid-run, then sequential count from the reset vector.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_rst_pc", pc_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_release_pc", pc_o, 32'h0);
    check("rst_empty", ras_empty_o, 1);
    tick(); check("seq_4", pc_o, 32'h4);
    tick(); check("seq_8", pc_o, 32'h8);
    tick(); check("seq_c", pc_o, 32'hC);

    // Freeze holds pc while a branch is requested.
    drive(0, 1, 0, 0, 32'h10); tick(); check("br_10", pc_o, 32'h10);
    drive(1, 1, 0, 0, 32'h80);
    repeat (3) begin
      tick();
      check("freeze_pc", pc_o, 32'h10);
      check("freeze_model_pc", m_pc, 32'h10);
    end

    // Call / return pair.
    drive(0, 1, 0, 0, 32'h20); tick(); check("br_20", pc_o, 32'h20);
    drive(0, 0, 1, 0, 32'h400); tick(); check("call_pc", pc_o, 32'h400);
    check("call_nonempty", ras_empty_o, 0);
    drive(0, 0, 0, 1, 32'h0);
    #1 check("ret_pc_next", pc_next_o, 32'h24);
    tick(); check("ret_pc", pc_o, 32'h24);
    check("ret_empty", ras_empty_o, 1);

    // Overflow then underflow.
    for (int i = 1; i <= 5; i++) begin
      drive(0, 0, 1, 0, 32'(i) << 12);
      tick();
    end
    check("ovf_full", ras_full_o, 1);
    check("ovf_flag", ras_ovf_o, 1);
    check("ovf_pc", pc_o, 32'h5000);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 32'h0);
      tick();
      check("ret_order", pc_o, rets[i]);
    end
    drive(0, 0, 0, 1, 32'h0); tick();
    check("unf_pc", pc_o, 32'h1008);
    check("unf_flag", ras_unf_o, 1);

    // Wrap-around and priority.
    drive(0, 1, 0, 0, 32'hFFFF_FFFC); tick(); check("br_top", pc_o, 32'hFFFF_FFFC);
    drive(0, 0, 0, 0, 32'h0); tick(); check("wrap_pc", pc_o, 32'h0);
    drive(0, 1, 1, 1, 32'h800); tick(); check("prio_call_pc", pc_o, 32'h800);
    check("prio_pushed", ras_empty_o, 0);
    drive(0, 0, 0, 1, 32'h0); tick(); check("prio_ret_pc", pc_o, 32'h4);

    // Misaligned branch target.
    drive(0, 1, 0, 0, 32'h402); tick();
`ifdef PC_ALIGN_CHECK_EN
    check("mis_pc", pc_o, 32'h100);
    check("mis_pulse", misalign_o, 1);
    drive(0, 0, 0, 0, 32'h0); tick();
    check("mis_clear", misalign_o, 0);
    check("mis_seq_pc", pc_o, 32'h104);
`else
    check("mis_pc", pc_o, 32'h402);
    check("mis_tied", misalign_o, 0);
`endif

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
            ($urandom_range(0, 7) == 0) ? 32'($urandom) : (32'($urandom) & ~32'h3));
      rst = ($urandom_range(0, 63) == 0);
    end
    drive(0, 0, 0, 0, 32'h0);
    rst = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
